// File: rtl/sw_debounce.sv
// sw_debounce: conditions the raw board switch vector for the CPU switch port.
// Raw levels are brought into clk with a two-flop synchroniser, sampled on a
// shared prescaler tick, and a bit only flips its clean value after it has
// disagreed with it on STABLE_CNT consecutive ticks. Flips produce one-cycle
// rise/fall pulses and set a sticky change flag that software clears.
module sw_debounce #(
  parameter int WIDTH      = 24,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             chg_clr,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             chg_flag,
  output logic             tick
);

  // Prescaler needs at least one bit even when TICK_DIV is 1.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  // A bit flips when the count is one short of STABLE_CNT and it still disagrees.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PRE_W-1:0] pre_cnt;

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] flip;

  // Two-flop synchroniser; only sync2 is used past this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Shared sample prescaler: registered tick is high for one cycle per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Per-bit stability counting; an agreeing sample wipes any partial count.
  always_comb begin
    differ  = sync2 ^ sw_clean;
    flip    = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (differ[i] && (cnt[i] == CNT_LAST)) begin
          flip[i]    = 1'b1;
          cnt_nxt[i] = '0;
        end else if (differ[i]) begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end else begin
          cnt_nxt[i] = '0;
        end
      end
    end
  end

  // Stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Clean levels and edge pulses update on the same edge, so a pulse is
  // visible in the first cycle the new level is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      sw_clean <= sw_clean ^ flip;
      sw_rise  <= flip & sync2;
      sw_fall  <= flip & ~sync2;
    end
  end

  // Sticky change flag; a new change beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_flag <= 1'b0;
    end else if (|flip) begin
      chg_flag <= 1'b1;
    end else if (chg_clr) begin
      chg_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: instance a uses TICK_DIV=1/STABLE_CNT=4,
// instance b uses TICK_DIV=3/STABLE_CNT=2. Expected values are hand-derived.
module tb_sw_debounce;

  logic        clk = 1'b0;

  logic        a_rst_n = 1'b0;
  logic [23:0] a_sw_raw = '0;
  logic        a_chg_clr = 1'b0;
  logic [23:0] a_clean, a_rise, a_fall;
  logic        a_chg, a_tick;

  logic        b_rst_n = 1'b0;
  logic [23:0] b_sw_raw = '0;
  logic        b_chg_clr = 1'b0;
  logic [23:0] b_clean, b_rise, b_fall;
  logic        b_chg, b_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(24), .TICK_DIV(1), .STABLE_CNT(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .sw_raw(a_sw_raw), .chg_clr(a_chg_clr),
    .sw_clean(a_clean), .sw_rise(a_rise), .sw_fall(a_fall),
    .chg_flag(a_chg), .tick(a_tick)
  );

  sw_debounce #(.WIDTH(24), .TICK_DIV(3), .STABLE_CNT(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .sw_raw(b_sw_raw), .chg_clr(b_chg_clr),
    .sw_clean(b_clean), .sw_rise(b_rise), .sw_fall(b_fall),
    .chg_flag(b_chg), .tick(b_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [23:0] clean, input logic [23:0] rise,
                         input logic [23:0] fall, input logic chg);
    check_val({tag, ".clean"}, 32'(a_clean), 32'(clean));
    check_val({tag, ".rise"},  32'(a_rise),  32'(rise));
    check_val({tag, ".fall"},  32'(a_fall),  32'(fall));
    check_val({tag, ".chg"},   32'(a_chg),   32'(chg));
  endtask

  initial begin
    // Reset state
    #1;
    check_a("rst0", 24'h0, 24'h0, 24'h0, 1'b0);
    check_val("rst0.tick", 32'(a_tick), 32'h0);
    #11 a_rst_n = 1'b1;
    step(2);
    check_val("a.tick_on", 32'(a_tick), 32'h1);

    // 1: single bit rise, clean on the 6th edge
    a_sw_raw = 24'h000001;
    step(5);
    check_a("t1.e5", 24'h0, 24'h0, 24'h0, 1'b0);
    step(1);
    check_a("t1.e6", 24'h000001, 24'h000001, 24'h0, 1'b1);
    step(1);
    check_a("t1.e7", 24'h000001, 24'h0, 24'h0, 1'b1);

    // clear with no change
    a_chg_clr = 1'b1;
    step(1);
    a_chg_clr = 1'b0;
    check_a("clr1", 24'h000001, 24'h0, 24'h0, 1'b0);

    // 2: bounce on bit 3 must leave no trace
    for (int k = 0; k < 4; k++) begin
      a_sw_raw[3] = (k % 2 == 0);
      step(1);
      check_a("t2.bounce", 24'h000001, 24'h0, 24'h0, 1'b0);
    end
    a_sw_raw[3] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check_a("t2.settle", 24'h000001, 24'h0, 24'h0, 1'b0);
    end

    // 3: back to 0, then all bits up, then all down
    a_sw_raw = 24'h0;
    step(6);
    check_a("t3.f0", 24'h0, 24'h0, 24'h000001, 1'b1);
    a_sw_raw = 24'hFFFFFF;
    step(5);
    check_a("t3.up5", 24'h0, 24'h0, 24'h0, 1'b1);
    step(1);
    check_a("t3.up6", 24'hFFFFFF, 24'hFFFFFF, 24'h0, 1'b1);
    step(1);
    check_a("t3.up7", 24'hFFFFFF, 24'h0, 24'h0, 1'b1);
    a_sw_raw = 24'h0;
    step(5);
    check_a("t3.dn5", 24'hFFFFFF, 24'h0, 24'h0, 1'b1);
    step(1);
    check_a("t3.dn6", 24'h0, 24'h0, 24'hFFFFFF, 1'b1);
    step(1);
    check_a("t3.dn7", 24'h0, 24'h0, 24'h0, 1'b1);

    // 4: set beats simultaneous clear; later clear works; clear at 0 is harmless
    a_chg_clr = 1'b1;
    step(1);
    a_chg_clr = 1'b0;
    check_val("t4.clr", 32'(a_chg), 32'h0);
    a_sw_raw = 24'h000001;
    step(5);
    a_chg_clr = 1'b1;
    step(1);
    a_chg_clr = 1'b0;
    check_a("t4.setwin", 24'h000001, 24'h000001, 24'h0, 1'b1);
    step(1);
    check_val("t4.hold", 32'(a_chg), 32'h1);
    a_chg_clr = 1'b1;
    step(1);
    a_chg_clr = 1'b0;
    check_val("t4.clr2", 32'(a_chg), 32'h0);
    a_chg_clr = 1'b1;
    step(1);
    a_chg_clr = 1'b0;
    check_a("t4.clr0", 24'h000001, 24'h0, 24'h0, 1'b0);

    // 6: async reset 2 ticks into a falling change
    a_sw_raw = 24'h0;
    step(4);
    check_a("t6.pre", 24'h000001, 24'h0, 24'h0, 1'b0);
    #3 a_rst_n = 1'b0;
    #1;
    check_a("t6.rst", 24'h0, 24'h0, 24'h0, 1'b0);
    check_val("t6.rst.tick", 32'(a_tick), 32'h0);
    a_sw_raw = 24'h000001;
    #2 a_rst_n = 1'b1;
    step(5);
    check_a("t6.e5", 24'h0, 24'h0, 24'h0, 1'b0);
    step(1);
    check_a("t6.e6", 24'h000001, 24'h000001, 24'h0, 1'b1);

    // 5: TICK_DIV=3, STABLE_CNT=2 on instance b
    check_val("t5.rst.tick", 32'(b_tick), 32'h0);
    check_val("t5.rst.clean", 32'(b_clean), 32'h0);
    #2 b_rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(1);
      check_val("t5.tick", 32'(b_tick), (k % 3 == 2) ? 32'h1 : 32'h0);
    end
    // held 4 cycles, only one tick sees it
    b_sw_raw = 24'h000001;
    step(4);
    check_val("t5.rej.mid", 32'(b_clean), 32'h0);
    b_sw_raw = 24'h0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check_val("t5.rej.clean", 32'(b_clean), 32'h0);
      check_val("t5.rej.rise", 32'(b_rise), 32'h0);
    end
    check_val("t5.rej.chg", 32'(b_chg), 32'h0);
    // held change: two ticks, clean on the 6th edge here
    b_sw_raw = 24'h000001;
    step(5);
    check_val("t5.acc.e5", 32'(b_clean), 32'h0);
    step(1);
    check_val("t5.acc.clean", 32'(b_clean), 32'h000001);
    check_val("t5.acc.rise", 32'(b_rise), 32'h000001);
    check_val("t5.acc.chg", 32'(b_chg), 32'h1);
    step(1);
    check_val("t5.acc.rise_off", 32'(b_rise), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
